int_sequencer: RTL and testbench

- Interrupt sequencer for the CPU's PC-select path.
- Edge-latches external IRQ lines, masks them and picks the highest-priority request.
- Waits for a safe instruction boundary: no stall, no branch/jump resolving.
- Drives int_en1 for exactly one cycle so the PC mux selects the interrupt vector, and captures EPC/cause. Stays in service until eret.

---
 rtl/int_sequencer_if.sv | 33 +++
 rtl/int_sequencer.sv | 105 ++++++++++
 tb/tb_int_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bus: IRQ inputs, mask write port, pipeline status and
// PC in from the core; PC-select control, EPC/cause and acknowledge out.
//   master : core/testbench side (drives irq, mask, stall, branch, pc, eret)
//   slave  : sequencer side (drives int_en1, flush, int_active, epc, cause, ack)
interface int_sequencer_if #(
   parameter int NIRQ  = 8,
   parameter int IDW   = 3,
   parameter int WIDTH = 32
);
   logic [NIRQ-1:0]  irq;
   logic             mask_we;
   logic [NIRQ-1:0]  mask_wdata;
   logic             stall;
   logic             branch_pending;
   logic [WIDTH-1:0] pc_cur;
   logic             eret;
   logic             int_en1;
   logic             flush;
   logic             int_active;
   logic [WIDTH-1:0] epc;
   logic [IDW-1:0]   cause;
   logic [NIRQ-1:0]  ack;

   modport master (
      output irq, mask_we, mask_wdata, stall, branch_pending, pc_cur, eret,
      input  int_en1, flush, int_active, epc, cause, ack
   );

   modport slave (
      input  irq, mask_we, mask_wdata, stall, branch_pending, pc_cur, eret,
      output int_en1, flush, int_active, epc, cause, ack
   );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt sequencer for the PC-select path. Rising edges on irq are latched
// into pending, qualified by mask, and the lowest-index request is taken at
// the first safe instruction boundary (no stall, no branch resolving).
// int_en1/flush pulse for one cycle while EPC/cause are captured; the block
// then stays in service until eret (no nesting).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : int_sequencer_if.slave (see interface for signal list)
// IDW must satisfy 2**IDW >= NIRQ.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no unmasked request outstanding
// ARM     | request present, waiting for no stall and no branch
// TAKE    | one-cycle vector select; epc/cause captured at exit edge
// SERVICE | handler running; leaves on eret
module int_sequencer #(
   parameter int NIRQ  = 8,
   parameter int IDW   = 3,
   parameter int WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   int_sequencer_if.slave     bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] TAKE    = 2'd2;
   localparam logic [1:0] SERVICE = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [NIRQ-1:0]  irq_q;
   logic [NIRQ-1:0]  pending;
   logic [NIRQ-1:0]  mask;
   logic [NIRQ-1:0]  req;
   logic [NIRQ-1:0]  sel_oh;
   logic [NIRQ-1:0]  ack_int;
   logic [IDW-1:0]   sel;
   logic [WIDTH-1:0] epc_r;
   logic [IDW-1:0]   cause_r;

   assign req = pending & mask;

   // Isolate lowest set bit: req & -req.
   assign sel_oh = req & (~req + NIRQ'(1));

   always_comb begin
      sel = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (req[i]) sel = IDW'(i);
      end
   end

   // sel_oh is already zero when req is empty, so a take with nothing left
   // unmasked acknowledges nothing.
   assign ack_int = (state == TAKE) ? sel_oh : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req != '0) state_nxt = ARM;
         ARM: begin
            if (req == '0)
               state_nxt = IDLE;
            else if (!bus.stall && !bus.branch_pending)
               state_nxt = TAKE;
         end
         TAKE:    state_nxt = SERVICE;
         SERVICE: if (bus.eret) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         irq_q   <= '0;
         pending <= '0;
         mask    <= '0;
         epc_r   <= '0;
         cause_r <= '0;
      end else begin
         state   <= state_nxt;
         irq_q   <= bus.irq;
         // Set term ORed last so a new edge wins over a same-cycle ack.
         pending <= (pending & ~ack_int) | (bus.irq & ~irq_q);
         if (bus.mask_we) mask <= bus.mask_wdata;
         if (state == TAKE) begin
            epc_r   <= bus.pc_cur;
            cause_r <= sel;
         end
      end
   end

   assign bus.int_en1    = (state == TAKE);
   assign bus.flush      = (state == TAKE);
   assign bus.int_active = (state == TAKE) || (state == SERVICE);
   assign bus.ack        = ack_int;
   assign bus.epc        = epc_r;
   assign bus.cause      = cause_r;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;
   localparam int NIRQ  = 8;
   localparam int IDW   = 3;
   localparam int WIDTH = 32;

   localparam int P_IDLE = 0, P_WAIT = 1, P_TAKE = 2, P_SVC = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int_sequencer_if #(.NIRQ(NIRQ), .IDW(IDW), .WIDTH(WIDTH)) bus ();

   int_sequencer #(.NIRQ(NIRQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pending/mask/previous-irq vectors plus a phase number.
   logic [NIRQ-1:0]  m_pend, m_mask, m_irqq;
   int               m_phase;
   logic [WIDTH-1:0] m_epc;
   logic [IDW-1:0]   m_cause;

   function automatic int lowest(input logic [NIRQ-1:0] v);
      for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [NIRQ-1:0] m_ack();
      logic [NIRQ-1:0] r;
      int k;
      r = m_pend & m_mask;
      k = lowest(r);
      if (m_phase != P_TAKE || k < 0) return '0;
      return NIRQ'(1) << k;
   endfunction

   task automatic model_clear();
      m_pend = '0; m_mask = '0; m_irqq = '0;
      m_phase = P_IDLE; m_epc = '0; m_cause = '0;
   endtask

   task automatic model_step();
      logic [NIRQ-1:0] r, a;
      int k;
      r = m_pend & m_mask;
      a = m_ack();
      k = lowest(r);
      if (m_phase == P_TAKE) begin
         m_epc   = bus.pc_cur;
         m_cause = (k < 0) ? '0 : IDW'(k);
      end
      m_pend = (m_pend & ~a) | (bus.irq & ~m_irqq);
      m_irqq = bus.irq;
      if (bus.mask_we) m_mask = bus.mask_wdata;
      case (m_phase)
         P_IDLE: if (r != 0) m_phase = P_WAIT;
         P_WAIT: if (r == 0) m_phase = P_IDLE;
                 else if (!bus.stall && !bus.branch_pending) m_phase = P_TAKE;
         P_TAKE: m_phase = P_SVC;
         default: if (bus.eret) m_phase = P_IDLE;
      endcase
   endtask

   // Advance one clock: model consumes the same pre-edge inputs as the DUT.
   task automatic tick();
      if (reset) model_clear();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.irq = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
      bus.stall = 1'b0; bus.branch_pending = 1'b0; bus.pc_cur = '0; bus.eret = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic write_mask(input logic [NIRQ-1:0] m);
      bus.mask_we = 1'b1; bus.mask_wdata = m;
      tick();
      bus.mask_we = 1'b0;
   endtask

   task automatic pulse_eret();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.int_en1 !== 1'b0) begin failures++; $display("FAIL reset_int_en1 got=%b exp=0", bus.int_en1); end
      checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
      checks++; if (bus.int_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus.int_active); end
      checks++; if (bus.ack !== 8'h00) begin failures++; $display("FAIL reset_ack got=%h exp=00", bus.ack); end
      checks++; if (bus.epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", bus.epc); end
      checks++; if (bus.cause !== 3'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", bus.cause); end
   endtask

   task automatic test_basic();
      int n;
      do_reset();
      write_mask(8'hFF);
      bus.pc_cur = 32'h0000_0100;
      bus.irq = 8'h08;
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      checks++; if (n != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", n); end
      checks++; if (bus.ack !== 8'h08) begin failures++; $display("FAIL basic_ack got=%h exp=08", bus.ack); end
      checks++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL basic_flush got=%b exp=1", bus.flush); end
      tick();
      checks++; if (bus.int_en1 !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", bus.int_en1); end
      checks++; if (bus.cause !== 3'd3) begin failures++; $display("FAIL basic_cause got=%0d exp=3", bus.cause); end
      checks++; if (bus.epc !== 32'h100) begin failures++; $display("FAIL basic_epc got=%h exp=100", bus.epc); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.int_active !== 1'b1) begin failures++; $display("FAIL basic_active got=%b exp=1", bus.int_active); end
      end
      pulse_eret();
      checks++; if (bus.int_active !== 1'b0) begin failures++; $display("FAIL basic_eret got=%b exp=0", bus.int_active); end
      bus.irq = '0;
   endtask

   task automatic test_priority();
      int n;
      do_reset();
      write_mask(8'hFF);
      bus.irq = 8'h24;
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      checks++; if (bus.ack !== 8'h04) begin failures++; $display("FAIL prio_ack1 got=%h exp=04", bus.ack); end
      tick();
      checks++; if (bus.cause !== 3'd2) begin failures++; $display("FAIL prio_cause1 got=%0d exp=2", bus.cause); end
      pulse_eret();
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      checks++; if (n != 2) begin failures++; $display("FAIL prio_rearm got=%0d exp=2", n); end
      checks++; if (bus.ack !== 8'h20) begin failures++; $display("FAIL prio_ack2 got=%h exp=20", bus.ack); end
      tick();
      checks++; if (bus.cause !== 3'd5) begin failures++; $display("FAIL prio_cause2 got=%0d exp=5", bus.cause); end
      pulse_eret();
      bus.irq = '0;
   endtask

   task automatic block_run(input bit use_stall, input int line);
      do_reset();
      write_mask(8'hFF);
      bus.irq = NIRQ'(1) << line;
      if (use_stall) bus.stall = 1'b1; else bus.branch_pending = 1'b1;
      tick();
      bus.irq = '0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.int_en1 !== 1'b0) begin failures++; $display("FAIL block_held stall=%0d got=%b exp=0", use_stall, bus.int_en1); end
      end
      bus.stall = 1'b0; bus.branch_pending = 1'b0;
      tick();
      checks++; if (bus.int_en1 !== 1'b1) begin failures++; $display("FAIL block_release stall=%0d got=%b exp=1", use_stall, bus.int_en1); end
      tick();
      checks++; if (bus.cause !== IDW'(line)) begin failures++; $display("FAIL block_cause got=%0d exp=%0d", bus.cause, line); end
      pulse_eret();
   endtask

   task automatic test_blocking();
      block_run(1'b0, 6);
      block_run(1'b1, 7);
   endtask

   task automatic test_masking();
      int n;
      do_reset();
      write_mask(8'h00);
      bus.irq = 8'h02; tick(); bus.irq = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.int_active !== 1'b0) begin failures++; $display("FAIL mask_notake got=%b exp=0", bus.int_active); end
      end
      write_mask(8'h02);
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      checks++; if (n != 2) begin failures++; $display("FAIL mask_unmask_lat got=%0d exp=2", n); end
      checks++; if (bus.ack !== 8'h02) begin failures++; $display("FAIL mask_ack got=%h exp=02", bus.ack); end
      tick();
      checks++; if (bus.cause !== 3'd1) begin failures++; $display("FAIL mask_cause got=%0d exp=1", bus.cause); end
      pulse_eret();
      // Drop the mask while waiting in ARM: must fall back without a take.
      write_mask(8'hFF);
      bus.stall = 1'b1;
      bus.irq = 8'h04; tick(); bus.irq = '0;
      tick();
      write_mask(8'h00);
      bus.stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (bus.int_en1 !== 1'b0 || bus.int_active !== 1'b0) begin
            failures++; $display("FAIL mask_arm_cancel en=%b act=%b exp=0", bus.int_en1, bus.int_active);
         end
      end
   endtask

   task automatic test_edge_nesting();
      int takes, n;
      do_reset();
      write_mask(8'hFF);
      bus.irq = 8'h01;
      takes = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (bus.int_en1) takes++; end
      checks++; if (takes != 1) begin failures++; $display("FAIL edge_level_takes got=%0d exp=1", takes); end
      bus.irq = 8'h11; tick(); bus.irq = 8'h01;
      takes = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (bus.int_en1) takes++; end
      checks++; if (takes != 0) begin failures++; $display("FAIL nest_takes got=%0d exp=0", takes); end
      bus.irq = '0;
      pulse_eret();
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      checks++; if (bus.ack !== 8'h10) begin failures++; $display("FAIL nest_ack got=%h exp=10", bus.ack); end
      tick();
      checks++; if (bus.cause !== 3'd4) begin failures++; $display("FAIL nest_cause got=%0d exp=4", bus.cause); end
      pulse_eret();
      pulse_eret();
      takes = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (bus.int_en1 || bus.int_active) takes++; end
      checks++; if (takes != 0) begin failures++; $display("FAIL eret_idle got=%0d exp=0", takes); end
   endtask

   task automatic test_async_reset();
      int n, takes;
      do_reset();
      write_mask(8'hFF);
      bus.pc_cur = 32'h0000_0200;
      bus.irq = 8'h01;
      n = 0;
      do begin tick(); n++; end while (!bus.int_en1 && n < 20);
      bus.irq = 8'h10; tick();
      bus.irq = '0; tick();
      checks++; if (bus.epc !== 32'h200 || bus.int_active !== 1'b1) begin
         failures++; $display("FAIL areset_pre epc=%h act=%b exp=200/1", bus.epc, bus.int_active);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.int_active !== 1'b0) begin failures++; $display("FAIL areset_active got=%b exp=0", bus.int_active); end
      checks++; if (bus.epc !== 32'h0) begin failures++; $display("FAIL areset_epc got=%h exp=0", bus.epc); end
      #1;
      reset = 1'b0;
      model_clear();
      write_mask(8'hFF);
      takes = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (bus.int_en1 || bus.int_active) takes++; end
      checks++; if (takes != 0) begin failures++; $display("FAIL areset_lost got=%0d exp=0", takes); end
   endtask

   task automatic test_random();
      logic [NIRQ-1:0] ea;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bus.irq            = NIRQ'($urandom) & NIRQ'($urandom) & NIRQ'($urandom);
         bus.mask_we        = ($urandom_range(0, 9) == 0);
         bus.mask_wdata     = NIRQ'($urandom);
         bus.stall          = ($urandom_range(0, 3) == 0);
         bus.branch_pending = ($urandom_range(0, 3) == 0);
         bus.pc_cur         = WIDTH'($urandom);
         bus.eret           = ($urandom_range(0, 4) == 0);
         tick();
         ea = m_ack();
         checks++; if (bus.int_en1 !== (m_phase == P_TAKE) || bus.flush !== (m_phase == P_TAKE)) begin
            failures++; $display("FAIL rnd_en c=%0d en=%b fl=%b exp=%b", c, bus.int_en1, bus.flush, m_phase == P_TAKE);
         end
         checks++; if (bus.int_active !== (m_phase >= P_TAKE)) begin
            failures++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, bus.int_active, m_phase >= P_TAKE);
         end
         checks++; if (bus.ack !== ea) begin failures++; $display("FAIL rnd_ack c=%0d got=%h exp=%h", c, bus.ack, ea); end
         checks++; if (bus.epc !== m_epc) begin failures++; $display("FAIL rnd_epc c=%0d got=%h exp=%h", c, bus.epc, m_epc); end
         checks++; if (bus.cause !== m_cause) begin failures++; $display("FAIL rnd_cause c=%0d got=%0d exp=%0d", c, bus.cause, m_cause); end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;
      model_clear();
      #3;
      test_reset();
      test_basic();
      test_priority();
      test_blocking();
      test_masking();
      test_edge_nesting();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
